// File: rtl/nmx1_pkg.sv
// Shared types and defaults for the NMX1 Wishbone-to-macro bridge.
package nmx1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEFAULT_ADDR_MASK = 32'h0000_0FFF;
  localparam int          DEFAULT_TIMEOUT   = 255;

  // Read data returned when the macro never answers.
  localparam logic [31:0] ERR_DATA = 32'h0000_0000;

  // True when the address falls inside the decoded window.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (adr & ~mask) == base;
  endfunction

endpackage

// File: rtl/nmx1_wb_ctrl_if.sv
// Wishbone slave-side bus bundle for the NMX1 bridge.
interface nmx1_wb_ctrl_if;

  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_dat_o
  );

endinterface

// File: rtl/nmx1_timeout_cnt.sv
// Saturating 16-bit wait counter; expired flags the cycle in which the
// count would reach TIMEOUT, so the macro gets exactly TIMEOUT cycles.
module nmx1_timeout_cnt
  import nmx1_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [16:0] LIMIT = 17'(TIMEOUT);

  logic [15:0] count;

  // Count waiting cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = ({1'b0, count} + 17'd1) >= LIMIT;

endmodule

// File: rtl/nmx1_wb_ctrl.sv
// Wishbone slave that forwards decoded accesses to the NMX1 macro
// request/acknowledge port, with timeout and abandoned-cycle draining.
module nmx1_wb_ctrl
  import nmx1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = DEFAULT_ADDR_MASK,
  parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 CLKin,
  input  logic                 RSTin,
  nmx1_wb_ctrl_if.slave        bus,
  output logic                 EN,
  output logic                 R_WB,
  output logic [31:0]          DI,
  output logic [31:0]          AD,
  output logic [3:0]           SEL,
  input  logic [31:0]          DO,
  input  logic                 func_ack
);

  state_t      state;
  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;
  logic        req_valid;
  logic        hit;
  logic        cnt_clr;
  logic        cnt_en;
  logic        expired;

  assign req_valid = bus.wb_cyc_i & bus.wb_stb_i;
  assign hit       = in_window(bus.wb_adr_i, BASE_ADDR, ADDR_MASK);
  assign cnt_clr   = (state == IDLE);
  assign cnt_en    = ((state == REQ) || (state == DRAIN)) && !func_ack;

  nmx1_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLKin),
    .rst_n   (RSTin),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // Terminations are only presented to a master that still holds its cycle.
  assign bus.wb_ack_o = ack_q & bus.wb_cyc_i;
  assign bus.wb_err_o = err_q & bus.wb_cyc_i;
  assign bus.wb_dat_o = dat_q;

  // Transfer sequencing: decode, macro handshake, termination and drain
  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      state <= IDLE;
      EN    <= 1'b0;
      R_WB  <= 1'b0;
      DI    <= 32'd0;
      AD    <= 32'd0;
      SEL   <= 4'd0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          // the strobe that caused an error pulse is still up for one edge
          if (req_valid && !err_q) begin
            if (hit) begin
              R_WB  <= ~bus.wb_we_i;
              DI    <= bus.wb_dat_i;
              AD    <= bus.wb_adr_i & ADDR_MASK;
              SEL   <= bus.wb_sel_i;
              EN    <= 1'b1;
              state <= REQ;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!bus.wb_cyc_i) begin
            if (func_ack || expired) begin
              EN    <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (func_ack) begin
            EN    <= 1'b0;
            ack_q <= 1'b1;
            if (R_WB) begin
              dat_q <= DO;
            end
            state <= RESP;
          end else if (expired) begin
            EN    <= 1'b0;
            err_q <= 1'b1;
            dat_q <= ERR_DATA;
            state <= IDLE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (func_ack || expired) begin
            EN    <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          EN    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmx1_wb_ctrl.sv
// Scoreboard bench for nmx1_wb_ctrl: a transaction-level model predicts the
// macro request, how long EN stays up, and the bus termination.
module tb_nmx1_wb_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] SPAN = 32'h0000_0FFF;
  localparam int          TMO  = 8;

  typedef struct {
    bit          is_err;
    bit          check_dat;
    logic [31:0] dat;
  } resp_t;

  typedef struct {
    logic        r_wb;
    logic [31:0] di;
    logic [31:0] ad;
    logic [3:0]  sel;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic        r_wb;
  logic [31:0] di;
  logic [31:0] ad;
  logic [3:0]  sel;
  logic [31:0] do_data;
  logic        func_ack;

  resp_t resp_q[$];
  mreq_t req_q[$];
  int    len_q[$];

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_dat = 32'd0;

  resp_t exp_r;
  mreq_t cur_req;
  bit    have_cur = 1'b0;
  logic  en_prev = 1'b0;
  int    en_len = 0;

  nmx1_wb_ctrl_if bus ();

  nmx1_wb_ctrl #(
    .BASE_ADDR (BASE),
    .ADDR_MASK (SPAN),
    .TIMEOUT   (TMO)
  ) dut (
    .CLKin    (clk),
    .RSTin    (rst_n),
    .bus      (bus),
    .EN       (en),
    .R_WB     (r_wb),
    .DI       (di),
    .AD       (ad),
    .SEL      (sel),
    .DO       (do_data),
    .func_ack (func_ack)
  );

  always #5 clk = ~clk;

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  // Transaction-level prediction: window hit, EN length, termination, data.
  task automatic model_push(input logic [31:0] addr, input logic we,
                            input logic [31:0] wdat, input logic [3:0] s,
                            input int delay, input logic [31:0] dov,
                            input int drop_after, input int reset_after);
    bit    in_win;
    bit    acked;
    resp_t r;
    mreq_t m;
    in_win = (addr >= BASE) && (addr <= BASE + SPAN);
    if (!in_win) begin
      r.is_err = 1'b1;
      r.check_dat = 1'b0;
      r.dat = 32'd0;
      resp_q.push_back(r);
      return;
    end
    m.r_wb = !we;
    m.di   = wdat;
    m.ad   = addr - BASE;
    m.sel  = s;
    req_q.push_back(m);
    if (reset_after > 0) begin
      len_q.push_back(reset_after);
      model_dat = 32'd0;
      return;
    end
    acked = (delay >= 1) && (delay <= TMO);
    len_q.push_back(acked ? delay : TMO);
    if (drop_after > 0) return;
    if (acked) begin
      if (!we) model_dat = dov;
      r.is_err = 1'b0;
    end else begin
      model_dat = 32'd0;
      r.is_err = 1'b1;
    end
    r.check_dat = 1'b1;
    r.dat = model_dat;
    resp_q.push_back(r);
  endtask

  // One bus transfer plus the macro's responder behaviour for it.
  task automatic apply_stimulus(input logic [31:0] addr, input logic we,
                                input logic [31:0] wdat, input logic [3:0] s,
                                input int delay, input logic [31:0] dov,
                                input int drop_after, input int reset_after,
                                output int end_edge);
    int en_cycles;
    bit seen_end;
    bit dropped;
    bit finished;
    en_cycles = 0;
    seen_end = 1'b0;
    dropped = 1'b0;
    finished = 1'b0;
    end_edge = -1;
    model_push(addr, we, wdat, s, delay, dov, drop_after, reset_after);
    @(negedge clk);
    #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = addr;
    bus.wb_dat_i = wdat;
    bus.wb_sel_i = s;
    do_data      = dov;
    func_ack     = 1'b0;
    for (int c = 0; c < 64 && !finished; c++) begin
      @(negedge clk);
      if (seen_end) begin
        #1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        func_ack = 1'b0;
        finished = 1'b1;
      end else if (dropped && !en) begin
        #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b0;
        func_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        bus.wb_cyc_i = 1'b0;
        finished = 1'b1;
      end else begin
        if (bus.wb_ack_o || bus.wb_err_o) begin
          seen_end = 1'b1;
          end_edge = c + 1;
        end
        if (en) en_cycles++;
        #1;
        func_ack = 1'b0;
        // a stray acknowledge while responding or idle must be ignored
        if (seen_end) func_ack = 1'b1;
        else if (en && en_cycles == delay) func_ack = 1'b1;
        if (en && drop_after > 0 && en_cycles == drop_after) begin
          bus.wb_cyc_i = 1'b0;
          bus.wb_stb_i = 1'b0;
          dropped = 1'b1;
        end
        if (en && reset_after > 0 && en_cycles == reset_after) begin
          rst_n = 1'b0;
          #1;
          check_output("rst_en", 32'(en), 32'd0);
          check_output("rst_r_wb", 32'(r_wb), 32'd0);
          check_output("rst_di", di, 32'd0);
          check_output("rst_ad", ad, 32'd0);
          check_output("rst_sel", 32'(sel), 32'd0);
          check_output("rst_ack", 32'(bus.wb_ack_o), 32'd0);
          check_output("rst_err", 32'(bus.wb_err_o), 32'd0);
          check_output("rst_dat", bus.wb_dat_o, 32'd0);
          bus.wb_cyc_i = 1'b0;
          bus.wb_stb_i = 1'b0;
          func_ack = 1'b0;
          @(negedge clk);
          #1;
          rst_n = 1'b1;
          finished = 1'b1;
        end
      end
    end
    check_output("txn_finished", 32'(finished), 32'd1);
    if (!finished) begin
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      func_ack = 1'b0;
    end
  endtask

  // Macro-side monitor: request fields at EN rise, stability, EN duration.
  always @(negedge clk) begin
    if (en) begin
      if (!en_prev) begin
        en_len = 0;
        if (req_q.size() == 0) begin
          check_output("en_unexpected", 32'(en), 32'd0);
          have_cur = 1'b0;
        end else begin
          cur_req = req_q.pop_front();
          have_cur = 1'b1;
        end
      end
      en_len++;
      if (have_cur) begin
        check_output("r_wb", 32'(r_wb), 32'(cur_req.r_wb));
        check_output("di", di, cur_req.di);
        check_output("ad", ad, cur_req.ad);
        check_output("sel", 32'(sel), 32'(cur_req.sel));
      end
    end else if (en_prev) begin
      if (len_q.size() > 0) check_output("en_len", en_len, len_q.pop_front());
      have_cur = 1'b0;
    end
    en_prev = en;
  end

  // Bus-side monitor: every termination is matched against the scoreboard.
  always @(negedge clk) begin
    if (bus.wb_ack_o && bus.wb_err_o) check_output("ack_err_overlap", 32'(bus.wb_err_o), 32'd0);
    if (bus.wb_ack_o || bus.wb_err_o) begin
      if (resp_q.size() == 0) begin
        check_output("resp_unexpected", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'd0);
      end else begin
        exp_r = resp_q.pop_front();
        check_output("resp_is_err", 32'(bus.wb_err_o), 32'(exp_r.is_err));
        if (exp_r.check_dat) check_output("resp_dat", bus.wb_dat_o, exp_r.dat);
      end
    end
  end

  initial begin
    int          edge_n;
    logic [31:0] a;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'd0;
    bus.wb_dat_i = 32'd0;
    bus.wb_sel_i = 4'd0;
    do_data      = 32'd0;
    func_ack     = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    check_output("init_en", 32'(en), 32'd0);
    check_output("init_r_wb", 32'(r_wb), 32'd0);
    check_output("init_di", di, 32'd0);
    check_output("init_ad", ad, 32'd0);
    check_output("init_sel", 32'(sel), 32'd0);
    check_output("init_ack", 32'(bus.wb_ack_o), 32'd0);
    check_output("init_err", 32'(bus.wb_err_o), 32'd0);
    check_output("init_dat", bus.wb_dat_o, 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed scenarios");
    apply_stimulus(32'h3000_0010, 1'b1, 32'hA5A5_5A5A, 4'hF, 3, 32'hDEAD_BEEF, 0, 0, edge_n);
    apply_stimulus(32'h3000_0004, 1'b0, 32'h0000_0000, 4'hF, 1, 32'h1234_5678, 0, 0, edge_n);
    check_output("read_ack_edge", edge_n, 32'd2);
    apply_stimulus(32'h4000_0000, 1'b1, 32'h1111_1111, 4'h3, 1, 32'h0, 0, 0, edge_n);
    apply_stimulus(32'h3000_0020, 1'b0, 32'h0000_0000, 4'hF, 0, 32'h5555_AAAA, 0, 0, edge_n);
    apply_stimulus(32'h3000_0030, 1'b1, 32'hCAFE_F00D, 4'h1, 3, 32'h0, 1, 0, edge_n);
    apply_stimulus(32'h3000_0040, 1'b0, 32'h0000_0000, 4'hF, 5, 32'h0BAD_0BAD, 0, 2, edge_n);
    repeat (3) @(negedge clk);
    apply_stimulus(32'h3000_0044, 1'b0, 32'h0000_0000, 4'hC, 2, 32'h8765_4321, 0, 0, edge_n);
    apply_stimulus(32'h3000_0FFC, 1'b0, 32'h0000_0000, 4'hF, TMO, 32'h7777_0000, 0, 0, edge_n);
    apply_stimulus(32'h3000_0FF8, 1'b1, 32'h0F0F_0F0F, 4'h6, TMO + 1, 32'h0, 0, 0, edge_n);
    apply_stimulus(32'h2FFF_FFFC, 1'b0, 32'h0000_0000, 4'hF, 1, 32'h9999_9999, 0, 0, edge_n);
    apply_stimulus(32'h3000_1000, 1'b1, 32'h2222_2222, 4'hF, 1, 32'h0, 0, 0, edge_n);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE + ($urandom & SPAN & 32'hFFFF_FFFC);
      apply_stimulus(a, 1'($urandom), $urandom, 4'($urandom),
                     int'($urandom_range(0, 11)), $urandom, 0, 0, edge_n);
    end

    repeat (4) @(negedge clk);
    check_output("resp_q_left", resp_q.size(), 32'd0);
    check_output("req_q_left", req_q.size(), 32'd0);
    check_output("len_q_left", len_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nmx1_wb_ctrl.md
NMX1_WB_CTRL -- requirements
Module: nmx1_wb_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, the base of the decoded Wishbone window.
REQ-002 SHALL have parameter ADDR_MASK, default 32'h0000_0FFF, the offset bits inside the window.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for func_ack (range 1..65535).
REQ-004 SHALL have one clock and one reset. Reset is asynchronous and active-low.
REQ-005 SHALL have these ports:
- CLKin  in  1  clock
- RSTin  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination
- wb_dat_o  out  32  read data
- EN  out  1  macro request
- R_WB  out  1  1 = read, 0 = write
- DI  out  32  macro write data
- AD  out  32  macro address
- SEL  out  4  macro byte select
- DO  in  32  macro read data
- func_ack  in  1  macro completion

Function
REQ-006 SHALL implement the FSM states IDLE, REQ, RESP and DRAIN.
REQ-007 In IDLE, when wb_cyc_i & wb_stb_i and (wb_adr_i & ~ADDR_MASK) == BASE_ADDR, SHALL do all of the following:
- register R_WB = ~wb_we_i
- register DI = wb_dat_i
- register AD = wb_adr_i & ADDR_MASK
- register SEL = wb_sel_i
- clear the timeout counter
- go to REQ.
REQ-008 In IDLE, on cyc & stb with an address outside the window, SHALL pulse wb_err_o for one cycle (next cycle) and return to IDLE without asserting EN.
REQ-009 EN SHALL be 1 exactly while in REQ or DRAIN. R_WB, DI, AD and SEL SHALL stay stable throughout.
REQ-010 In REQ, on func_ack = 1, SHALL do all of the following:
- deassert EN at the next edge
- load wb_dat_o with DO if a read, or hold it if a write
- go to RESP.
REQ-011 In RESP, SHALL assert wb_ack_o for exactly one cycle, then go to IDLE. A transfer still asserting stb on the following cycle is a new request.
REQ-012 Minimum latency: request sampled at edge 0, EN high from edge 1, func_ack at edge 1 gives wb_ack_o high during cycle 2.
REQ-013 In REQ, the timeout counter SHALL increment each cycle with no func_ack. On reaching TIMEOUT, SHALL do all of the following:
- deassert EN
- set wb_dat_o = 32'h0000_0000
- pulse wb_err_o for one cycle instead of wb_ack_o
- go to IDLE.
REQ-014 If func_ack and the timeout occur in the same cycle, func_ack SHALL win (normal ack).
REQ-015 If wb_cyc_i drops while in REQ, SHALL go to DRAIN. DRAIN keeps EN high until func_ack or timeout, then goes to IDLE with no ack or err.
REQ-016 func_ack SHALL be ignored in IDLE and RESP.
REQ-017 wb_ack_o and wb_err_o SHALL never be high in the same cycle, and SHALL never be high outside a cycle with wb_cyc_i = 1.
REQ-018 The timeout counter SHALL be 16 bits and saturate, never wrapping.

Reset
REQ-019 While RSTin = 0, SHALL set the state to IDLE and all of the following outputs and registers to 0: EN, R_WB, DI, AD, SEL, wb_ack_o, wb_err_o, wb_dat_o, the counter.
REQ-020 Reset asserted mid-transfer SHALL abort immediately, with EN low asynchronously and no ack or err after release.

Structure
REQ-021 Package nmx1_pkg SHALL hold the state enum, the default BASE_ADDR/ADDR_MASK/TIMEOUT constants, and the error-data constant.
REQ-022 The timeout counter SHALL be a sub-module nmx1_timeout_cnt (inputs clr, en; output expired). The FSM and datapath stay in nmx1_wb_ctrl.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Write to 0x3000_0010 with data 0xA5A5_5A5A, sel 0xF, func_ack after 3 cycles -> EN high 3 cycles, AD = 0x010, DI = 0xA5A5_5A5A, R_WB = 0, one wb_ack_o.
- Read to 0x3000_0004 with DO = 0x1234_5678 and func_ack on the first EN cycle -> wb_dat_o = 0x1234_5678, ack in cycle 2.
- Access to 0x4000_0000 -> one wb_err_o cycle, EN never high.
- func_ack withheld, TIMEOUT = 8 -> EN high 8 cycles, then wb_err_o, wb_dat_o = 0.
- wb_cyc_i dropped during REQ, func_ack 2 cycles later -> EN holds until func_ack, no ack or err.
- RSTin low during REQ -> EN = 0 immediately, all outputs 0, next transfer completes normally.
